register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 105 ++++++++++
 tb/tb_register_file.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Register file with hardwired r0, sub-word write merging, same-cycle write bypass,
// and a halt-triggered dump of every register over a valid/ready stream.
module register_file #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REG_ADDR_LEN-1:0] addr,
  input  logic [WIDTH-1:0]        data,
  input  logic                    wr_en,
  input  logic [1:0]              w_mode,
  input  logic                    Halt,
  input  logic [REG_ADDR_LEN-1:0] rd_addr_a,
  input  logic [REG_ADDR_LEN-1:0] rd_addr_b,
  output logic [WIDTH-1:0]        rd_data_a,
  output logic [WIDTH-1:0]        rd_data_b,
  output logic                    dump_valid,
  input  logic                    dump_ready,
  output logic [REG_ADDR_LEN-1:0] dump_addr,
  output logic [WIDTH-1:0]        dump_data,
  output logic                    dump_done
);

  localparam int DEPTH = 1 << REG_ADDR_LEN;

  typedef enum logic [1:0] {RUN, DUMP, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [REG_ADDR_LEN-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0]        reg_view [DEPTH];
  logic [WIDTH-1:0]        wr_merged;
  logic                    wr_ok;

  // Writes are only honoured while running; r0 and the reserved mode never write.
  assign wr_ok = wr_en && (state_reg == RUN) && (addr != '0) && (w_mode != 2'd3);

  always_comb begin
    wr_merged = reg_view[addr];
    case (w_mode)
      2'd0:    wr_merged       = data;
      2'd1:    wr_merged[15:0] = data[15:0];
      2'd2:    wr_merged[7:0]  = data[7:0];
      default: wr_merged       = reg_view[addr];
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign reg_view[gi] = '0;
      end else begin : g_store
        logic [WIDTH-1:0] q_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            q_reg <= '0;
          end else if (wr_ok && (addr == REG_ADDR_LEN'(gi))) begin
            q_reg <= wr_merged;
          end
        end
        assign reg_view[gi] = q_reg;
      end
    end
  endgenerate

  // wr_ok already excludes r0 and non-RUN states, so the bypass inherits both.
  assign rd_data_a = (wr_ok && (rd_addr_a == addr)) ? wr_merged : reg_view[rd_addr_a];
  assign rd_data_b = (wr_ok && (rd_addr_b == addr)) ? wr_merged : reg_view[rd_addr_b];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (Halt) state_next = DUMP;
      end
      DUMP: begin
        if (dump_ready) begin
          // Last beat parks the counter at the top index instead of wrapping.
          if (cnt_reg == '1) state_next = DONE;
          else               cnt_next   = cnt_reg + REG_ADDR_LEN'(1);
        end
      end
      DONE:    state_next = DONE;
      default: state_next = RUN;
    endcase
  end

  assign dump_valid = (state_reg == DUMP);
  assign dump_done  = (state_reg == DONE);
  assign dump_addr  = cnt_reg;
  assign dump_data  = reg_view[cnt_reg];

endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file: an array-based reference model is checked on
// every falling edge, with literal expectations around the directed scenarios.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  addr = '0;
  logic [31:0] data = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  w_mode = '0;
  logic        Halt = 1'b0;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;
  logic [31:0] rd_data_a, rd_data_b;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_done;

  register_file #(.WIDTH(32), .REG_ADDR_LEN(5)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data(data), .wr_en(wr_en),
    .w_mode(w_mode), .Halt(Halt), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: 32 words, phase 0=run 1=dump 2=done, dump index.
  logic [31:0] m_mem [32];
  int          m_phase = 0;
  int          m_idx = 0;

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] mode);
    logic [31:0] mask;
    mask = (mode == 2'd0) ? 32'hFFFF_FFFF : (mode == 2'd1) ? 32'h0000_FFFF : 32'h0000_00FF;
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic bit m_wr_ok();
    return (m_phase == 0) && wr_en && (addr != 5'd0) && (w_mode != 2'd3);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (m_wr_ok() && (addr == ra)) return m_merge(m_mem[ra], data, w_mode);
    return m_mem[ra];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      m_phase = 0;
      m_idx = 0;
    end else if (m_phase == 0) begin
      if (m_wr_ok()) m_mem[addr] = m_merge(m_mem[addr], data, w_mode);
      if (Halt) m_phase = 1;
    end else if (m_phase == 1 && dump_ready) begin
      if (m_idx == 31) m_phase = 2;
      else m_idx = m_idx + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        chk("rst rd_a", rd_data_a, 32'h0);
        chk("rst valid", 32'(dump_valid), 32'h0);
        chk("rst done", 32'(dump_done), 32'h0);
        chk("rst dump_addr", 32'(dump_addr), 32'h0);
      end else begin
        chk("rd_a", rd_data_a, m_read(rd_addr_a));
        chk("rd_b", rd_data_b, m_read(rd_addr_b));
        chk("valid", 32'(dump_valid), 32'(m_phase == 1));
        chk("done", 32'(dump_done), 32'(m_phase == 2));
        if (m_phase == 1) begin
          chk("dump_addr", 32'(dump_addr), 32'(m_idx));
          chk("dump_data", dump_data, m_mem[m_idx]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [1:0] m);
    addr = a; data = d; w_mode = m; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      wr_en = 1'($urandom_range(0, 1));
      addr = 5'($urandom_range(0, 31));
      data = $urandom;
      w_mode = 2'($urandom_range(0, 3));
      rd_addr_a = 5'($urandom_range(0, 31));
      rd_addr_b = ($urandom_range(0, 2) == 0) ? addr : 5'($urandom_range(0, 31));
      tick();
    end
    wr_en = 1'b0;
  endtask

  logic        pat [4];
  int          beats, cyc;
  bit          prev_stall;
  logic [4:0]  prev_addr;
  logic [31:0] prev_data;

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("async rst valid", 32'(dump_valid), 32'h0);
    chk("async rst done", 32'(dump_done), 32'h0);
    chk("async rst dump_addr", 32'(dump_addr), 32'h0);
    chk("async rst rd", rd_data_a, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    rand_cycles(300);

    // Merge sequence on r5.
    rd_addr_a = 5'd5;
    wr(5'd5, 32'hDEAD_BEEF, 2'd0); chk("r5 word", rd_data_a, 32'hDEAD_BEEF);
    wr(5'd5, 32'h0000_1234, 2'd1); chk("r5 half", rd_data_a, 32'hDEAD_1234);
    wr(5'd5, 32'h0000_00AA, 2'd2); chk("r5 byte", rd_data_a, 32'hDEAD_12AA);

    // r0 hardwired, bypass on r7.
    addr = 5'd0; data = 32'hFFFF_FFFF; w_mode = 2'd0; wr_en = 1'b1; rd_addr_a = 5'd0;
    #1 chk("r0 bypass", rd_data_a, 32'h0);
    tick(); wr_en = 1'b0;
    chk("r0 after", rd_data_a, 32'h0);
    addr = 5'd7; data = 32'h11; wr_en = 1'b1; rd_addr_b = 5'd7;
    #1 chk("r7 bypass", rd_data_b, 32'h11);
    tick(); wr_en = 1'b0;
    chk("r7 after", rd_data_b, 32'h11);

    // Reserved mode leaves r9 untouched and does not bypass.
    wr(5'd9, 32'h9, 2'd0);
    addr = 5'd9; data = 32'hFFFF_FFFF; w_mode = 2'd3; wr_en = 1'b1; rd_addr_a = 5'd9;
    #1 chk("r9 mode3 bypass", rd_data_a, 32'h9);
    tick(); wr_en = 1'b0;
    chk("r9 mode3 after", rd_data_a, 32'h9);

    // Halt with concurrent write, then a write during DUMP is ignored.
    addr = 5'd3; data = 32'h55; w_mode = 2'd0; wr_en = 1'b1; Halt = 1'b1; dump_ready = 1'b0;
    tick();
    Halt = 1'b0; data = 32'h66; rd_addr_a = 5'd3;
    #1 chk("r3 no bypass in dump", rd_data_a, 32'h55);
    chk("dump valid after halt", 32'(dump_valid), 32'h1);
    chk("dump addr after halt", 32'(dump_addr), 32'h0);
    tick(); wr_en = 1'b0;
    chk("r3 kept", rd_data_a, 32'h55);

    // Dump with backpressure pattern 1,0,0,1.
    beats = 0; cyc = 0; prev_stall = 1'b0;
    while (!dump_done && cyc < 400) begin
      dump_ready = pat[cyc % 4];
      Halt = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        chk("stall addr hold", 32'(dump_addr), 32'(prev_addr));
        chk("stall data hold", dump_data, prev_data);
      end
      prev_stall = 1'b0;
      if (dump_valid && dump_ready) begin
        chk("beat order", 32'(dump_addr), 32'(beats));
        case (beats)
          0: chk("beat r0", dump_data, 32'h0);
          3: chk("beat r3", dump_data, 32'h55);
          5: chk("beat r5", dump_data, 32'hDEAD_12AA);
          7: chk("beat r7", dump_data, 32'h11);
          9: chk("beat r9", dump_data, 32'h9);
          default: ;
        endcase
        beats++;
      end else if (dump_valid) begin
        prev_stall = 1'b1; prev_addr = dump_addr; prev_data = dump_data;
      end
      tick();
      cyc++;
    end
    chk("beat count", 32'(beats), 32'd32);
    chk("dump_done", 32'(dump_done), 32'h1);
    Halt = 1'b1; dump_ready = 1'b1;
    tick(); tick();
    chk("done stays", 32'(dump_done), 32'h1);
    chk("valid low in done", 32'(dump_valid), 32'h0);
    Halt = 1'b0; dump_ready = 1'b0;

    // Reset mid-dump.
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    rand_cycles(100);
    Halt = 1'b1; tick(); Halt = 1'b0;
    cyc = 0;
    while (!(dump_valid && dump_addr == 5'd10) && cyc < 400) begin
      dump_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    chk("reached beat 10", 32'(dump_addr), 32'd10);
    rst_n = 1'b0; rd_addr_a = 5'd5;
    #1;
    chk("mid-dump rst valid", 32'(dump_valid), 32'h0);
    chk("mid-dump rst addr", 32'(dump_addr), 32'h0);
    chk("mid-dump rst data", dump_data, 32'h0);
    chk("mid-dump rst rd", rd_data_a, 32'h0);
    tick(); tick();
    rst_n = 1'b1; dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
      #1 chk("cleared a", rd_data_a, 32'h0);
      chk("cleared b", rd_data_b, 32'h0);
    end
    chk("run after rst", 32'(dump_valid), 32'h0);
    rd_addr_a = 5'd1;
    wr(5'd1, 32'hA5, 2'd0);
    chk("first write after rst", rd_data_a, 32'hA5);
    rand_cycles(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
